poly_tone_mixer: RTL
====================

Name: poly_tone_mixer

Overview:
- Parametrised polyphonic tone generator and mixer: NUM_CH independent oscillators, per-channel waveform select, saturating sum into one signed sample for Audio_Controller left/right inputs.
- Replaces per-note wave instances plus the ad-hoc adder in the top level.
- Adds exact-period counters, pulse/noise modes, saturation, and an audio_out_allowed handshake.

Parameters:
- NUM_CH, 8, number of oscillator channels (1..16)
- CNT_W, 32, width of each period count (hz)
- AMP_W, 32, signed output sample width
- AMPLITUDE, 30000000, per-channel peak magnitude; must be < 2^(AMP_W-1)

Ports:
- clock  in  1  system clock (CLOCK_50 domain)
- reset  in  1  synchronous, active-low reset (asserted when 0)
- play_note  in  NUM_CH  per-channel gate
- hz  in  NUM_CH*CNT_W  per-channel period in clock cycles; channel i at [i*CNT_W +: CNT_W]
- wave_sel  in  NUM_CH*2  per-channel mode: 00 square, 01 25% pulse, 10 12.5% pulse, 11 noise
- audio_out_allowed  in  1  sink ready; sample register updates only when 1
- audio_out  out  AMP_W  signed mixed sample
- write_audio_out  out  1  registered; 1 when a nonzero sample was loaded this cycle
- clear_audio_out_memory  out  1  registered; 1 when mix sum is zero
- active  out  NUM_CH  per-channel "contributing" flag

Behaviour:
- Reset (reset==0 at posedge): all counters 0, all channel amplitude registers 0, LFSR[i] = 16'hACE1 ^ i, audio_out=0, write_audio_out=0, clear_audio_out_memory=1, active=0. Reset overrides every other input.
- Channel counter, with P = hz[i] sampled at load time:
  - play_note low: counter held at P-1, contribution 0.
  - play_note high: counter decrements each cycle; at 0 it reloads current hz-1. Period is exactly hz cycles.
  - A change to hz mid-period takes effect only at the next reload.
- hz < 2: channel silent (contribution 0, counter held), active=0.
- Level: D = 1, 2, 3 for modes 00, 01, 10. Channel is high when counter >= P - (P >> D), otherwise low. Contribution is +AMPLITUDE when high, -AMPLITUDE when low.
- Noise (11): 16-bit Fibonacci LFSR, taps 16,14,13,11, stepped when counter==0 and when counter==P>>1. Contribution is +AMPLITUDE if LFSR[0]==1, else -AMPLITUDE.
- wave_sel changes are applied combinationally on the next cycle; no phase reset.
- Pipeline:
  - Stage 1: registered per-channel contribution.
  - Stage 2: signed sum at width AMP_W+clog2(NUM_CH)+1, saturated to [-2^(AMP_W-1), 2^(AMP_W-1)-1], then registered into audio_out only when audio_out_allowed==1. Otherwise audio_out holds.
- Latency: play_note rising at cycle N gives the first contribution in stage 1 at N+1 and on audio_out at N+2, given audio_out_allowed=1.
- Output flags:
  - write_audio_out <= audio_out_allowed && (saturated sum != 0).
  - clear_audio_out_memory <= (saturated sum == 0), evaluated every cycle regardless of allowed.
- active[i] = play_note[i] && hz[i] >= 2, registered with stage 1.
- Simultaneous wrap and play_note fall: fall wins; counter goes to P-1, contribution 0.

Optional Feature:
- Macro: POLY_TONE_ENVELOPE_EN.
- When defined, each channel has an 8-bit gain and a shared ENV_DIV=1024 prescaler. On each prescaler tick, gain increments (saturating at 255) while play_note is high, and decrements (floor 0) while low.
- Contribution becomes (raw * gain) >>> 8. The oscillator keeps running after play_note falls while gain > 0.
- active[i] = gain != 0. Reset clears gain to 0. Latency increases by 1 cycle (multiply register).
- When undefined: gain is effectively 256 (pass-through), note-off is immediate, and there is no multiplier.

Test Plan:
- NUM_CH=4, AMP_W=16, AMPLITUDE=100; ch0 hz=8 mode 00, play rises at cycle 0 -> audio_out = +100 for cycles 2-5, -100 for cycles 6-9, period 8. write_audio_out=1 throughout.
- Same setup, mode 01 -> +100 for 2 cycles, -100 for 6 per period. Mode 10 -> +100 for 1 cycle, -100 for 7.
- AMPLITUDE=20000, all 4 channels hz=8 mode 00 started together -> audio_out = 32767 during high phase and -32768 during low phase (saturated, no wrap).
- ch0 playing, audio_out_allowed held 0 for 5 cycles -> audio_out frozen at its last value, write_audio_out=0. Resumes on the cycle after allowed returns to 1.
- ch0 hz=1 -> audio_out=0, clear_audio_out_memory=1, active=0. Then hz changed 8->4 mid-period -> old period completes, new 4-cycle period follows.
- reset driven 0 mid-note for 1 cycle -> next cycle audio_out=0, clear=1. With play held, the tone restarts in the high phase from counter P-1. Mode 11: sign sequence matches a reference LFSR seeded 16'hACE1.

Source files
------------

// File: rtl/poly_tone_mixer.sv
// Polyphonic tone generator: NUM_CH period-exact oscillators mixed into one saturated signed sample.
// Define POLY_TONE_ENVELOPE_EN to add per-channel 8-bit attack/release gain with a multiply stage.
module poly_tone_mixer #(
   parameter int NUM_CH    = 8,
   parameter int CNT_W     = 32,
   parameter int AMP_W     = 32,
   parameter int AMPLITUDE = 30000000
) (
   input  logic                      clock,
   input  logic                      reset,
   input  logic [NUM_CH-1:0]         play_note,
   input  logic [NUM_CH*CNT_W-1:0]   hz,
   input  logic [NUM_CH*2-1:0]       wave_sel,
   input  logic                      audio_out_allowed,
   output logic signed [AMP_W-1:0]   audio_out,
   output logic                      write_audio_out,
   output logic                      clear_audio_out_memory,
   output logic [NUM_CH-1:0]         active
);

   localparam int SUM_W = AMP_W + $clog2(NUM_CH) + 1;
   localparam logic signed [AMP_W-1:0] AMP_POS = AMP_W'(AMPLITUDE);
   localparam logic signed [AMP_W-1:0] AMP_NEG = -AMP_POS;
   localparam logic signed [SUM_W-1:0] SAT_MAX = SUM_W'({1'b0, {(AMP_W-1){1'b1}}});
   localparam logic signed [SUM_W-1:0] SAT_MIN = ~SAT_MAX;
   localparam logic [15:0]             LFSR_SEED = 16'hACE1;

   // Fibonacci LFSR, taps 16,14,13,11, shifting toward bit 0.
   function automatic logic [15:0] lfsr_next(input logic [15:0] s);
      logic fb;
      fb = s[0] ^ s[2] ^ s[3] ^ s[5];
      return {fb, s[15:1]};
   endfunction

   logic signed [AMP_W-1:0] contrib_s [NUM_CH];
   logic [NUM_CH-1:0]       act_s;

`ifdef POLY_TONE_ENVELOPE_EN
   logic [9:0] presc_q;
   logic [9:0] presc_d;
   logic       env_tick_s;

   assign env_tick_s = (presc_q == 10'd1023);
   assign presc_d    = presc_q + 10'd1;

   // Shared envelope prescaler, one tick every 1024 clocks.
   always_ff @(posedge clock) begin
      if (!reset) begin
         presc_q <= 10'd0;
      end else begin
         presc_q <= presc_d;
      end
   end
`endif

   for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
      logic [CNT_W-1:0]        hz_s;
      logic [1:0]              mode_s;
      logic [CNT_W-1:0]        thr_s;
      logic                    gate_s;
      logic                    run_s;
      logic [CNT_W-1:0]        cnt_q;
      logic [CNT_W-1:0]        cnt_d;
      logic [CNT_W-1:0]        per_q;
      logic [CNT_W-1:0]        per_d;
      logic [15:0]             lfsr_q;
      logic [15:0]             lfsr_d;
      logic signed [AMP_W-1:0] raw_q;
      logic signed [AMP_W-1:0] raw_d;

      assign hz_s   = hz[g*CNT_W +: CNT_W];
      assign mode_s = wave_sel[g*2 +: 2];

`ifdef POLY_TONE_ENVELOPE_EN
      logic [7:0]              gain_q;
      logic [7:0]              gain_d;
      logic signed [AMP_W+8:0] prod_s;
      logic signed [AMP_W-1:0] mul_q;
      logic signed [AMP_W-1:0] mul_d;

      // Oscillator keeps ringing through the release while gain is nonzero.
      assign gate_s       = play_note[g] || (gain_q != 8'd0);
      assign act_s[g]     = (gain_q != 8'd0);
      assign prod_s       = raw_q * $signed({1'b0, gain_q});
      assign mul_d        = AMP_W'(prod_s >>> 8);
      assign contrib_s[g] = mul_q;

      always_comb begin
         gain_d = gain_q;
         if (env_tick_s) begin
            if (play_note[g]) begin
               if (gain_q != 8'hFF) begin
                  gain_d = gain_q + 8'd1;
               end else begin
                  gain_d = gain_q;
               end
            end else begin
               if (gain_q != 8'h00) begin
                  gain_d = gain_q - 8'd1;
               end else begin
                  gain_d = gain_q;
               end
            end
         end else begin
            gain_d = gain_q;
         end
      end

      always_ff @(posedge clock) begin
         if (!reset) begin
            gain_q <= 8'd0;
            mul_q  <= '0;
         end else begin
            gain_q <= gain_d;
            mul_q  <= mul_d;
         end
      end
`else
      assign gate_s       = play_note[g];
      assign act_s[g]     = play_note[g] && (hz_s >= CNT_W'(2));
      assign contrib_s[g] = raw_q;
`endif

      // A period below 2 (including the zero left by reset) forces a reload rather than running.
      assign run_s = gate_s && (hz_s >= CNT_W'(2)) && (per_q >= CNT_W'(2));

      // High-phase threshold: P - (P >> D) with D = 1, 2, 3.
      always_comb begin
         case (mode_s)
            2'b00:   thr_s = per_q - (per_q >> 3'd1);
            2'b01:   thr_s = per_q - (per_q >> 3'd2);
            2'b10:   thr_s = per_q - (per_q >> 3'd3);
            default: thr_s = per_q - (per_q >> 3'd1);
         endcase
      end

      always_comb begin
         cnt_d  = cnt_q;
         per_d  = per_q;
         lfsr_d = lfsr_q;
         raw_d  = '0;
         if (run_s) begin
            if (cnt_q == '0) begin
               cnt_d = hz_s - CNT_W'(1);
               per_d = hz_s;
            end else begin
               cnt_d = cnt_q - CNT_W'(1);
               per_d = per_q;
            end
            if ((cnt_q == '0) || (cnt_q == (per_q >> 3'd1))) begin
               lfsr_d = lfsr_next(lfsr_q);
            end else begin
               lfsr_d = lfsr_q;
            end
            if (mode_s == 2'b11) begin
               raw_d = lfsr_q[0] ? AMP_POS : AMP_NEG;
            end else begin
               raw_d = (cnt_q >= thr_s) ? AMP_POS : AMP_NEG;
            end
         end else begin
            cnt_d = hz_s - CNT_W'(1);
            per_d = hz_s;
         end
      end

      always_ff @(posedge clock) begin
         if (!reset) begin
            cnt_q  <= '0;
            per_q  <= '0;
            lfsr_q <= LFSR_SEED ^ 16'(g);
            raw_q  <= '0;
         end else begin
            cnt_q  <= cnt_d;
            per_q  <= per_d;
            lfsr_q <= lfsr_d;
            raw_q  <= raw_d;
         end
      end
   end

   logic signed [SUM_W-1:0] sum_s;
   logic signed [AMP_W-1:0] sat_s;
   logic signed [AMP_W-1:0] audio_q;
   logic signed [AMP_W-1:0] audio_d;
   logic                    write_q;
   logic                    write_d;
   logic                    clear_q;
   logic                    clear_d;
   logic [NUM_CH-1:0]       active_q;

   // Wide signed sum cannot overflow; clamp afterwards to the output range.
   always_comb begin
      sum_s = '0;
      for (int i = 0; i < NUM_CH; i++) begin
         sum_s = sum_s + {{(SUM_W-AMP_W){contrib_s[i][AMP_W-1]}}, contrib_s[i]};
      end
      if (sum_s > SAT_MAX) begin
         sat_s = SAT_MAX[AMP_W-1:0];
      end else if (sum_s < SAT_MIN) begin
         sat_s = SAT_MIN[AMP_W-1:0];
      end else begin
         sat_s = sum_s[AMP_W-1:0];
      end
   end

   always_comb begin
      audio_d = audio_q;
      if (audio_out_allowed) begin
         audio_d = sat_s;
      end else begin
         audio_d = audio_q;
      end
      write_d = audio_out_allowed && (sat_s != '0);
      clear_d = (sat_s == '0);
   end

   always_ff @(posedge clock) begin
      if (!reset) begin
         audio_q  <= '0;
         write_q  <= 1'b0;
         clear_q  <= 1'b1;
         active_q <= '0;
      end else begin
         audio_q  <= audio_d;
         write_q  <= write_d;
         clear_q  <= clear_d;
         active_q <= act_s;
      end
   end

   assign audio_out              = audio_q;
   assign write_audio_out        = write_q;
   assign clear_audio_out_memory = clear_q;
   assign active                 = active_q;

endmodule
